// File: rtl/rtcl_p3s7_frame_fixer_if.sv
// Image stream bundle: start-of-frame, end-of-line, pixel data, valid/ready.
interface rtcl_p3s7_frame_fixer_if #(
  parameter int DATA_BITS = 10
);
  logic                 tuser;
  logic                 tlast;
  logic [DATA_BITS-1:0] tdata;
  logic                 tvalid;
  logic                 tready;

  modport master (output tuser, tlast, tdata, tvalid, input tready);
  modport slave  (input tuser, tlast, tdata, tvalid, output tready);
endinterface

// File: rtl/rtcl_p3s7_frame_fixer.sv
// Frame fixer: turns a possibly damaged sensor stream into frames of exactly
// width x height pixels. Short lines and short frames are padded, long lines
// are trimmed. A single output register stage sits between input and output.
module rtcl_p3s7_frame_fixer #(
  parameter int X_BITS    = 10,
  parameter int Y_BITS    = 10,
  parameter int DATA_BITS = 10,
  parameter int PAD_DATA  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [X_BITS-1:0]          param_width,
  input  logic [Y_BITS-1:0]          param_height,
  input  logic                       stat_clear,
  rtcl_p3s7_frame_fixer_if.slave     s,
  rtcl_p3s7_frame_fixer_if.master    m,
  output logic                       stat_short_line,
  output logic                       stat_long_line,
  output logic                       stat_short_frame,
  output logic                       frame_done
);

  typedef enum logic [2:0] {IDLE, RUN, DROP, PAD_LINE, PAD_FRAME} state_t;

  state_t               state_q, state_d;
  logic [X_BITS-1:0]    x_q, x_d, w_q, w_d;
  logic [Y_BITS-1:0]    y_q, y_d, h_q, h_d;
  logic                 m_vld_q, m_vld_d;
  logic                 m_user_q, m_user_d;
  logic                 m_last_q, m_last_d;
  logic [DATA_BITS-1:0] m_data_q, m_data_d;
  logic                 eof_q, eof_d;
  logic                 sl_q, sl_d, ll_q, ll_d, sf_q, sf_d;

  logic                 s_rdy, out_free, pos_zero;
  logic                 pix, pad, last_col, last_row;
  logic                 sl_set, ll_set, sf_set;
  logic [X_BITS-1:0]    cw, cx;
  logic [Y_BITS-1:0]    ch, cy;

  assign out_free = !m_vld_q || m.tready;
  assign pos_zero = (x_q == '0) && (y_q == '0);

  // Next-state: pick the active pixel source (input or pad), advance the
  // counters and the state, and load the output register when it frees up.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    w_d      = w_q;
    h_d      = h_q;
    m_vld_d  = m_vld_q && !m.tready;
    m_user_d = m_user_q;
    m_last_d = m_last_q;
    m_data_d = m_data_q;
    eof_d    = eof_q;
    s_rdy    = 1'b0;
    pix      = 1'b0;
    pad      = 1'b0;
    sl_set   = 1'b0;
    ll_set   = 1'b0;
    sf_set   = 1'b0;
    cw       = w_q;
    ch       = h_q;
    cx       = x_q;
    cy       = y_q;

    case (state_q)
      IDLE: begin
        // Geometry is latched only here, so mid-frame changes are ignored.
        s_rdy = out_free;
        if (s.tvalid && out_free && s.tuser) begin
          w_d = param_width;
          h_d = param_height;
          if (param_width != '0 && param_height != '0) begin
            pix = 1'b1;
            cw  = param_width;
            ch  = param_height;
            cx  = '0;
            cy  = '0;
          end
        end
      end
      RUN: begin
        // An early SOF is held off until the current frame is padded out.
        if (s.tuser && !pos_zero) begin
          if (s.tvalid) begin
            sf_set  = 1'b1;
            state_d = PAD_FRAME;
          end
        end else begin
          s_rdy = out_free;
          pix   = s.tvalid && out_free;
        end
      end
      DROP: begin
        if (s.tuser && !pos_zero) begin
          if (s.tvalid) begin
            sf_set  = 1'b1;
            state_d = PAD_FRAME;
          end
        end else begin
          s_rdy = 1'b1;
          if (s.tvalid && s.tlast) state_d = RUN;
        end
      end
      PAD_LINE, PAD_FRAME: pad = out_free;
      default: state_d = IDLE;
    endcase

    last_col = (cx == cw - X_BITS'(1));
    last_row = (cy == ch - Y_BITS'(1));

    if (pix || pad) begin
      m_vld_d  = 1'b1;
      m_user_d = pix && (cx == '0) && (cy == '0);
      m_last_d = last_col;
      m_data_d = pix ? s.tdata : DATA_BITS'(PAD_DATA);
      eof_d    = last_col && last_row;
      x_d      = last_col ? '0 : cx + X_BITS'(1);
      y_d      = last_col ? (last_row ? '0 : cy + Y_BITS'(1)) : cy;
    end

    if (pix) begin
      if (last_col && last_row) begin
        // Frame ends here; any excess input is discarded by IDLE.
        state_d = IDLE;
        ll_set  = !s.tlast;
      end else if (last_col) begin
        state_d = s.tlast ? RUN : DROP;
        ll_set  = !s.tlast;
      end else if (s.tlast) begin
        state_d = PAD_LINE;
        sl_set  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end

    if (pad && last_col) begin
      if (last_row)                 state_d = IDLE;
      else if (state_q == PAD_LINE) state_d = RUN;
    end

    // A set in the same cycle as a clear wins.
    sl_d = sl_set || (sl_q && !stat_clear);
    ll_d = ll_set || (ll_q && !stat_clear);
    sf_d = sf_set || (sf_q && !stat_clear);
  end

  // State, counters, output stage and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      m_vld_q  <= 1'b0;
      m_user_q <= 1'b0;
      m_last_q <= 1'b0;
      m_data_q <= '0;
      eof_q    <= 1'b0;
      sl_q     <= 1'b0;
      ll_q     <= 1'b0;
      sf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      w_q      <= w_d;
      h_q      <= h_d;
      m_vld_q  <= m_vld_d;
      m_user_q <= m_user_d;
      m_last_q <= m_last_d;
      m_data_q <= m_data_d;
      eof_q    <= eof_d;
      sl_q     <= sl_d;
      ll_q     <= ll_d;
      sf_q     <= sf_d;
    end
  end

  assign s.tready         = s_rdy;
  assign m.tvalid         = m_vld_q;
  assign m.tuser          = m_user_q;
  assign m.tlast          = m_last_q;
  assign m.tdata          = m_data_q;
  assign stat_short_line  = sl_q;
  assign stat_long_line   = ll_q;
  assign stat_short_frame = sf_q;
  assign frame_done       = m_vld_q && m.tready && eof_q;

endmodule

// File: tb/tb_rtcl_p3s7_frame_fixer.sv
// Directed bench for the frame fixer with an expected-beat scoreboard.
module tb_rtcl_p3s7_frame_fixer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] param_width;
  logic [9:0] param_height;
  logic       stat_clear;
  logic       stat_short_line, stat_long_line, stat_short_frame, frame_done;

  rtcl_p3s7_frame_fixer_if #(.DATA_BITS(10)) s_if ();
  rtcl_p3s7_frame_fixer_if #(.DATA_BITS(10)) m_if ();

  rtcl_p3s7_frame_fixer #(.X_BITS(10), .Y_BITS(10), .DATA_BITS(10), .PAD_DATA(0)) dut (
    .clk              (clk),
    .reset            (reset),
    .param_width      (param_width),
    .param_height     (param_height),
    .stat_clear       (stat_clear),
    .s                (s_if),
    .m                (m_if),
    .stat_short_line  (stat_short_line),
    .stat_long_line   (stat_long_line),
    .stat_short_frame (stat_short_frame),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          fd_cnt = 0;
  logic        bp_en  = 1'b0;
  logic [11:0] exp_q[$];
  logic        stall_q = 1'b0;
  logic [11:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic want(input logic u, input logic l, input logic [9:0] d);
    exp_q.push_back({u, l, d});
  endtask

  // Drives one beat and holds it until the DUT takes it (bounded).
  task automatic send(input logic u, input logic l, input logic [9:0] d);
    int   n  = 0;
    logic hs = 1'b0;
    s_if.tuser  = u;
    s_if.tlast  = l;
    s_if.tdata  = d;
    s_if.tvalid = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = s_if.tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) begin
      chk("send_timeout", 32'(hs), 1);
      s_if.tvalid = 1'b0;
    end
  endtask

  task automatic s_idle();
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    s_idle();
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    chk("stat_cleared", {stat_short_line, stat_long_line, stat_short_frame}, 0);
  endtask

  // Sends a clean frame of the given geometry starting at data value base.
  task automatic clean_frame(input int w, input int h, input logic [9:0] base);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        want(x == 0 && y == 0, x == w - 1, base + 10'(y * w + x));
        send(x == 0 && y == 0, x == w - 1, base + 10'(y * w + x));
      end
  endtask

  // Random downstream backpressure when enabled.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pop, stall stability, frame_done count.
  always @(negedge clk) begin
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q)
        chk("stall_stable", {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}, {1'b1, held});
      if (m_if.tvalid && m_if.tready) begin
        chk("beat_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0)
          chk("beat", {m_if.tuser, m_if.tlast, m_if.tdata}, exp_q.pop_front());
      end
      if (frame_done) fd_cnt++;
      stall_q = m_if.tvalid && !m_if.tready;
      held    = {m_if.tuser, m_if.tlast, m_if.tdata};
    end
  end

  initial begin
    reset        = 1'b1;
    param_width  = 10'd4;
    param_height = 10'd2;
    stat_clear   = 1'b0;
    s_if.tdata   = '0;
    s_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}, 0);
    chk("rst_stat", {stat_short_line, stat_long_line, stat_short_frame, frame_done}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready", 32'(s_if.tready), 1);

    // Zero width: SOF is swallowed, nothing comes out.
    param_width = 10'd0;
    send(1, 0, 10'd5);
    send(0, 1, 10'd6);
    drain("zero_w_drain");
    chk("zero_w_fd", fd_cnt, 0);
    param_width = 10'd4;

    // Clean frame; geometry change after SOF must not matter.
    want(1, 0, 10'd1);
    send(1, 0, 10'd1);
    chk("latency", {m_if.tvalid, m_if.tuser, m_if.tdata}, {2'b11, 10'd1});
    param_width = 10'd7;
    for (int i = 1; i < 8; i++) begin
      want(0, i % 4 == 3, 10'(i + 1));
      send(0, i % 4 == 3, 10'(i + 1));
    end
    drain("clean_drain");
    param_width = 10'd4;
    chk("clean_fd", fd_cnt, 1);
    chk("clean_stat", {stat_short_line, stat_long_line, stat_short_frame}, 0);

    // Short line 0: padded out to width.
    want(1, 0, 10'd10); want(0, 0, 10'd11); want(0, 0, 10'd0); want(0, 1, 10'd0);
    want(0, 0, 10'd12); want(0, 0, 10'd13); want(0, 0, 10'd14); want(0, 1, 10'd15);
    send(1, 0, 10'd10); send(0, 1, 10'd11);
    send(0, 0, 10'd12); send(0, 0, 10'd13); send(0, 0, 10'd14); send(0, 1, 10'd15);
    drain("short_line_drain");
    chk("short_line_fd", fd_cnt, 2);
    chk("short_line_stat", {stat_short_line, stat_long_line, stat_short_frame}, 3'b100);
    clear_stats();

    // Long line 0: excess pixels dropped, tlast forced.
    want(1, 0, 10'd20); want(0, 0, 10'd21); want(0, 0, 10'd22); want(0, 1, 10'd23);
    want(0, 0, 10'd26); want(0, 0, 10'd27); want(0, 0, 10'd28); want(0, 1, 10'd29);
    send(1, 0, 10'd20); send(0, 0, 10'd21); send(0, 0, 10'd22); send(0, 0, 10'd23);
    send(0, 0, 10'd24); send(0, 1, 10'd25);
    send(0, 0, 10'd26); send(0, 0, 10'd27); send(0, 0, 10'd28); send(0, 1, 10'd29);
    drain("long_line_drain");
    chk("long_line_fd", fd_cnt, 3);
    chk("long_line_stat", {stat_short_line, stat_long_line, stat_short_frame}, 3'b010);
    clear_stats();

    // Early SOF after 5 pixels: 3 pads, then the new frame.
    want(1, 0, 10'd30); want(0, 0, 10'd31); want(0, 0, 10'd32); want(0, 1, 10'd33);
    want(0, 0, 10'd34); want(0, 0, 10'd0); want(0, 0, 10'd0); want(0, 1, 10'd0);
    send(1, 0, 10'd30); send(0, 0, 10'd31); send(0, 0, 10'd32); send(0, 1, 10'd33);
    send(0, 0, 10'd34);
    clean_frame(4, 2, 10'd40);
    drain("short_frame_drain");
    chk("short_frame_fd", fd_cnt, 5);
    chk("short_frame_stat", {stat_short_line, stat_long_line, stat_short_frame}, 3'b001);
    clear_stats();

    // Clean frame under random backpressure.
    bp_en = 1'b1;
    clean_frame(4, 2, 10'd50);
    drain("bp_drain");
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_fd", fd_cnt, 6);

    // Reset after 3 beats out aborts the frame.
    want(1, 0, 10'd60); want(0, 0, 10'd61); want(0, 0, 10'd62);
    send(1, 0, 10'd60); send(0, 0, 10'd61); send(0, 0, 10'd62);
    s_idle();
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
    chk("pre_reset_beats", exp_q.size(), 0);
    #1;
    reset = 1'b1;
    #1;
    chk("reset_tvalid", 32'(m_if.tvalid), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(0, 0, 10'd99); send(0, 1, 10'd98); send(0, 0, 10'd97);
    clean_frame(4, 2, 10'd70);
    drain("post_reset_drain");
    chk("post_reset_fd", fd_cnt, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rtcl_p3s7_frame_fixer.md
RTCL_P3S7_FRAME_FIXER -- requirements
Module: rtcl_p3s7_frame_fixer

Interface
REQ-001 SHALL have parameter X_BITS, default 10: width of column counters and width setting.
REQ-002 SHALL have parameter Y_BITS, default 10: width of row counters and height setting.
REQ-003 SHALL have parameter DATA_BITS, default 10: pixel width (RAW10).
REQ-004 SHALL have parameter PAD_DATA, default 0: pixel value emitted when padding.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port clk  input  1: single clock; all logic runs on its rising edge.
REQ-007 SHALL have port param_width  input  X_BITS: pixels per line; sampled at frame start.
REQ-008 SHALL have port param_height  input  Y_BITS: lines per frame; sampled at frame start.
REQ-009 SHALL have port stat_clear  input  1: clears sticky status flags.
REQ-010 SHALL have ports s_tuser (1, start of frame), s_tlast (1, end of line), s_tdata (DATA_BITS), s_tvalid (1): inputs from the HS D-PHY receiver image stream.
REQ-011 SHALL have port s_tready  output  1: input accept.
REQ-012 SHALL have ports m_tuser, m_tlast, m_tdata (DATA_BITS), m_tvalid: outputs carrying the corrected stream.
REQ-013 SHALL have port m_tready  input  1: downstream accept.
REQ-014 SHALL have ports stat_short_line, stat_long_line, stat_short_frame  output  1 each: sticky error flags.
REQ-015 SHALL have port frame_done  output  1: one-cycle pulse when the last pixel of a frame is accepted downstream.

Function
REQ-016 SHALL deliver a stream of exactly param_width x param_height beats per frame, m_tuser=1 only on pixel (0,0) and m_tlast=1 only on column param_width-1.
REQ-017 SHALL implement states IDLE, RUN, DROP, PAD_LINE, PAD_FRAME.
REQ-018 IDLE: s_tready=1; beats without s_tuser are discarded; a beat with s_tuser latches width/height, sets x=0, y=0, and is processed as RUN's first pixel.
REQ-019 IDLE with latched width=0 or height=0: the SOF beat is discarded and state remains IDLE.
REQ-020 RUN: each accepted input beat is forwarded with its tdata; x increments, wrapping to 0 and incrementing y after column width-1.
REQ-021 RUN, input s_tlast on column < width-1: that pixel is forwarded without tlast, stat_short_line set, state PAD_LINE.
REQ-022 RUN, column width-1 forwarded without s_tlast: stat_long_line set, state DROP.
REQ-023 DROP: s_tready=1, beats discarded, no output; the beat with s_tlast returns to RUN (or IDLE if frame complete); a beat with s_tuser in DROP is handled per REQ-025.
REQ-024 PAD_LINE: s_tready=0; emits PAD_DATA up to column width-1 with m_tlast, then RUN (or IDLE if frame complete).
REQ-025 RUN/DROP, input s_tuser at (x,y) != (0,0): the beat is not consumed (s_tready=0), stat_short_frame set, state PAD_FRAME.
REQ-026 PAD_FRAME: s_tready=0; emits PAD_DATA with correct tlast until the frame is complete, then IDLE, where the pending SOF beat is accepted.
REQ-027 Frame complete = pixel (width-1, height-1) accepted downstream; frame_done pulses that cycle; state becomes IDLE; x,y reset to 0.
REQ-028 Output SHALL be a single register stage: latency one cycle from input accept to m_tvalid; in passing states s_tready = !m_tvalid || m_tready.
REQ-029 m_tvalid SHALL not drop and m_t* SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-030 Width/height changes during a frame SHALL have no effect until next SOF in IDLE.
REQ-031 stat_* SHALL be set on events and cleared only by stat_clear; simultaneous clear and set SHALL leave the flag set.
REQ-032 Counters SHALL be X_BITS/Y_BITS unsigned; no arithmetic overflow is permitted given width,height <= 2^BITS-1.

Reset
REQ-033 On reset: state IDLE, x=0, y=0, m_tvalid=0, m_tuser=0, m_tlast=0, m_tdata=0, frame_done=0, stat_*=0, latched width/height=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no further output beats; after release the block waits for SOF.

Verification
REQ-035 Width=4, height=2, clean 8-beat frame, m_tready=1 -> identical 8 beats out, 1-cycle latency, tuser on beat 0, tlast on beats 3 and 7, frame_done once.
REQ-036 Width=4, height=2, line 0 ends with tlast after 2 pixels -> output line 0 = 2 data + 2 PAD_DATA with tlast on 4th; stat_short_line=1; 8 beats total.
REQ-037 Width=4, height=2, line 0 has 6 pixels -> pixels 4,5 dropped, tlast forced on 4th, stat_long_line=1.
REQ-038 Width=4, height=2, new SOF after 5 pixels -> 3 PAD beats (tlast on last), frame_done, then new frame starts with that SOF pixel; stat_short_frame=1.
REQ-039 Random m_tready backpressure (~50%) on REQ-035 stimulus -> same output sequence, m_t* stable while stalled, no beat lost.
REQ-040 Reset asserted after 3 beats out -> m_tvalid=0 immediately; garbage beats without tuser after release are discarded; next SOF frame correct.
